// File: rtl/scpu_multicycle.sv
// Multi-cycle sCPU core: host-loaded program RAM, FETCH/EXEC/WB sequencing,
// run / single-step / halt control and debug observation ports.
module scpu_multicycle #(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int PROG_DEPTH = 16,
  localparam int RW = $clog2(NUM_REGS),
  localparam int PW = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [15:0]       prog_data,
  input  logic [RW-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PW-1:0]     pc_out,
  output logic [15:0]       instruction,
  output logic [DATA_W-1:0] alu_out,
  output logic [2:0]        state,
  output logic              busy,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_LI   = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t              cur, nxt;
  logic [15:0]         mem [PROG_DEPTH];
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [PW-1:0]       pc;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   alu_q;
  logic                take_br;
  logic                step_pend;
  logic                illegal_q;

  logic [3:0]          op;
  logic [RW-1:0]       rd, rs1, rs2;
  logic [PW-1:0]       addr;
  logic [DATA_W-1:0]   result;
  logic                br_cond;
  logic                wr_en;
  logic                reserved;

  assign op       = ir[15:12];
  assign rd       = ir[8 +: RW];
  assign rs1      = ir[4 +: RW];
  assign rs2      = ir[0 +: RW];
  assign addr     = ir[PW-1:0];
  assign wr_en    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_LI);
  assign reserved = (op >= 4'd6) && (op <= 4'd14);

  always_comb begin
    result  = '0;
    br_cond = 1'b0;
    case (op)
      OP_ADD:  result  = regs[rs1] + regs[rs2];
      OP_SUB:  result  = regs[rs1] - regs[rs2];
      OP_LI:   result  = DATA_W'(ir[7:0]);
      OP_BNE:  br_cond = (regs[rd] != regs[0]);
      OP_BEQ:  br_cond = (regs[rd] == regs[0]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  // A captured step forces the return to IDLE after WB even if run rises meanwhile.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (run || step) nxt = S_FETCH;
      S_FETCH:  nxt = S_EXEC;
      S_EXEC:   nxt = S_WB;
      S_WB: begin
        if (op == OP_HALT)          nxt = S_HALTED;
        else if (run && !step_pend) nxt = S_FETCH;
        else                        nxt = S_IDLE;
      end
      S_HALTED: nxt = S_HALTED;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      ir        <= '0;
      alu_q     <= '0;
      take_br   <= 1'b0;
      step_pend <= 1'b0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (cur)
        S_IDLE:  step_pend <= step && !run;
        S_FETCH: ir <= mem[pc];
        S_EXEC: begin
          alu_q   <= result;
          take_br <= br_cond;
        end
        S_WB: begin
          if (wr_en) regs[rd] <= alu_q;
          if (op != OP_HALT) pc <= take_br ? addr : pc + PW'(1);
          if (reserved) illegal_q <= 1'b1;
          step_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Program RAM has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && (cur == S_IDLE || cur == S_HALTED)) mem[prog_addr] <= prog_data;
  end

  assign dbg_data    = regs[dbg_sel];
  assign pc_out      = pc;
  assign instruction = ir;
  assign alu_out     = alu_q;
  assign state       = cur;
  assign busy        = (cur == S_FETCH) || (cur == S_EXEC) || (cur == S_WB);
  assign retire      = (cur == S_WB);
  assign halted      = (cur == S_HALTED);
  assign illegal     = illegal_q;

endmodule
